// File: rtl/scope_pkg.sv
// Shared constants and FSM encoding for the oscilloscope capture buffer.
// Modules that override these through parameters must keep DEPTH a power of two.
package scope_pkg;

    localparam int DEPTH        = 64;
    localparam int PRE_TRIG     = 16;
    localparam int AUTO_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_PRE   = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Strobes collected after the trigger sample so the frame fills exactly DEPTH entries.
    function automatic int post_strobes(input int depth, input int pre_trig);
        return depth - pre_trig - 1;
    endfunction

endpackage

// File: rtl/scope_capture_buffer_if.sv
// Display-side read bus of the capture buffer: the display indexes the frozen frame
// and receives sample data plus the frame status flags.
interface scope_capture_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 6
);
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          frame_valid;
    logic          auto_trig;

    modport master (output rd_addr, input rd_data, frame_valid, auto_trig);
    modport slave  (input rd_addr, output rd_data, frame_valid, auto_trig);
endinterface

// File: rtl/scope_capture_buffer_trig_detect.sv
// Level-crossing detector: compares the previous and current strobed samples
// against the threshold in the selected slope direction.
module scope_trig_detect #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] prev_sample,
    input  logic [DW-1:0] signal,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_slope,
    output logic          hit
);
    logic rise;
    logic fall;

    // Unsigned compares; a sample sitting on the level counts as crossed.
    assign rise = (prev_sample < trig_level) && (signal >= trig_level);
    assign fall = (prev_sample > trig_level) && (signal <= trig_level);
    assign hit  = trig_slope ? rise : fall;
endmodule

// File: rtl/scope_capture_buffer.sv
// Pre/post-trigger sample capture into a circular RAM, frozen in HOLD until rearm,
// with decimation and an optional timeout-forced trigger.
module scope_capture_buffer #(
    parameter int DW           = 16,
    parameter int DEPTH        = scope_pkg::DEPTH,
    parameter int PRE_TRIG     = scope_pkg::PRE_TRIG,
    parameter int AUTO_TIMEOUT = scope_pkg::AUTO_TIMEOUT
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic [DW-1:0]         signal,
    input  logic [DW-1:0]         trig_level,
    input  logic                  trig_slope,
    input  logic [7:0]            decim,
    input  logic                  auto_mode,
    input  logic                  rearm,
    scope_capture_buffer_if.slave disp
);
    import scope_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(AUTO_TIMEOUT + DEPTH) + 1;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(post_strobes(DEPTH, PRE_TRIG) - 1);
    localparam logic [CW-1:0] TIMEOUT   = CW'(AUTO_TIMEOUT);

    state_t        state, state_n;
    logic [7:0]    dec_cnt;
    logic          strobe;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] trig_ptr, trig_ptr_n;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] prev_sample;
    logic [DW-1:0] rd_q;
    logic          auto_q, auto_n;
    logic          wr_en;
    logic          hit;

    logic [DW-1:0] mem [DEPTH];

    assign strobe = (dec_cnt == decim);

    scope_trig_detect #(.DW(DW)) u_trig (
        .prev_sample (prev_sample),
        .signal      (signal),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .hit         (hit)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PRE;
            cnt         <= '0;
            trig_ptr    <= '0;
            auto_q      <= 1'b0;
            dec_cnt     <= '0;
            wr_ptr      <= '0;
            prev_sample <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            trig_ptr <= trig_ptr_n;
            auto_q   <= auto_n;
            dec_cnt  <= strobe ? 8'd0 : dec_cnt + 8'd1;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (strobe)
                prev_sample <= signal;
        end
    end

    // One shared counter: PRE fill count, ARMED timeout count, POST fill count.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        trig_ptr_n = trig_ptr;
        auto_n     = auto_q;
        wr_en      = strobe && (state != ST_HOLD);
        if (rearm) begin
            // Rearm wins over a coincident trigger; the pending frame is dropped.
            state_n = ST_PRE;
            cnt_n   = '0;
            auto_n  = 1'b0;
        end else if (strobe) begin
            case (state)
                ST_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state_n = ST_ARMED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_ARMED: begin
                    if (hit || (auto_mode && cnt == TIMEOUT)) begin
                        state_n    = ST_POST;
                        cnt_n      = '0;
                        trig_ptr_n = wr_ptr;
                        auto_n     = !hit;
                    end else if (cnt != TIMEOUT) begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_POST: begin
                    if (cnt == POST_LAST) begin
                        state_n = ST_HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem[wr_ptr] <= signal;
    end

    // Display index 0 maps to PRE_TRIG entries before the trigger sample.
    assign rd_ptr = trig_ptr - AW'(PRE_TRIG) + disp.rd_addr;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            rd_q <= '0;
        else
            rd_q <= mem[rd_ptr];
    end

    assign disp.rd_data     = rd_q;
    assign disp.frame_valid = (state == ST_HOLD);
    assign disp.auto_trig   = auto_q;
endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for the capture buffer: ramp, decimated ramp, auto trigger,
// falling square wave, rearm/trigger collision and reset during capture.
module tb_scope_capture_buffer;
    logic        CLOCK_50   = 1'b0;
    logic        reset_n    = 1'b0;
    logic [15:0] signal     = '0;
    logic [15:0] trig_level = 16'd100;
    logic        trig_slope = 1'b1;
    logic [7:0]  decim      = 8'd0;
    logic        auto_mode  = 1'b0;
    logic        rearm      = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    scope_capture_buffer_if #(.DW(16), .AW(6)) disp ();

    scope_capture_buffer dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .signal     (signal),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .decim      (decim),
        .auto_mode  (auto_mode),
        .rearm      (rearm),
        .disp       (disp)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wave(input int kind, input int p);
        case (kind)
            0:       wave = 16'(p & 255);
            1:       wave = 16'(p);
            2:       wave = 16'd50;
            default: wave = ((p / 8) % 2 == 0) ? 16'd200 : 16'd0;
        endcase
    endfunction

    // Index p drives the sample taken at the next rising edge; frame_valid seen
    // at index p reflects the edge of index p-1. Returns -1 if HOLD never shows.
    task automatic run(input int kind, input int start, input int stop,
                       input int rearm_at, output int rise);
        rise = -1;
        for (int p = start; p <= stop; p++) begin
            if (p != start) @(negedge CLOCK_50);
            if (disp.frame_valid === 1'b1) begin
                rise = p;
                break;
            end
            signal = wave(kind, p);
            rearm  = (p == rearm_at);
        end
        rearm = 1'b0;
    endtask

    task automatic rd(input int a, output logic [15:0] d);
        @(negedge CLOCK_50);
        disp.rd_addr = 6'(a);
        @(negedge CLOCK_50);
        d = disp.rd_data;
    endtask

    initial begin
        int          rise;
        logic [15:0] d;
        disp.rd_addr = '0;

        repeat (3) @(negedge CLOCK_50);
        chk("reset rd_data", 32'(disp.rd_data), 32'd0);
        chk("reset frame_valid", 32'(disp.frame_valid), 32'd0);
        chk("reset auto_trig", 32'(disp.auto_trig), 32'd0);

        // Ramp 0..255, rising through 100: trigger on sample 100 at index 100.
        reset_n = 1'b1;
        run(0, 0, 400, -1, rise);
        chk("ramp hold index", 32'(rise), 32'd148);
        rd(16, d); chk("ramp rd16", 32'(d), 32'd100);
        rd(0, d);  chk("ramp rd0", 32'(d), 32'd84);
        rd(1, d);  chk("ramp rd1", 32'(d), 32'd85);
        rd(63, d); chk("ramp rd63", 32'(d), 32'd147);
        chk("ramp auto_trig", 32'(disp.auto_trig), 32'd0);

        // Reset while frozen drops the frame; then decim=3 on a 16-bit ramp.
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        chk("hold reset frame_valid", 32'(disp.frame_valid), 32'd0);
        chk("hold reset rd_data", 32'(disp.rd_data), 32'd0);
        decim   = 8'd3;
        reset_n = 1'b1;
        // Strobes at indices 3,7,11..; trigger sample 103 (prev 99); 47 post strobes * 4 clocks.
        run(1, 0, 400, -1, rise);
        chk("decim hold index", 32'(rise), 32'd292);
        rd(16, d); chk("decim rd16", 32'(d), 32'd103);
        rd(0, d);  chk("decim rd0", 32'(d), 32'd39);
        rd(1, d);  chk("decim rd1", 32'(d), 32'd43);
        rd(63, d); chk("decim rd63", 32'(d), 32'd291);

        // Constant 50 below level 100 with auto: 16 PRE + 4096 ARMED, forced at index 4112.
        @(negedge CLOCK_50);
        reset_n   = 1'b0;
        decim     = 8'd0;
        auto_mode = 1'b1;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        run(2, 0, 5000, -1, rise);
        chk("auto hold index", 32'(rise), 32'd4160);
        chk("auto auto_trig", 32'(disp.auto_trig), 32'd1);
        for (int k = 0; k < 64; k++) begin
            rd(k, d);
            chk($sformatf("auto rd%0d", k), 32'(d), 32'd50);
        end

        // Rearm from HOLD clears the flags on the next cycle; no auto means no frame.
        @(negedge CLOCK_50);
        rearm     = 1'b1;
        auto_mode = 1'b0;
        @(negedge CLOCK_50);
        rearm = 1'b0;
        chk("rearm frame_valid", 32'(disp.frame_valid), 32'd0);
        chk("rearm auto_trig", 32'(disp.auto_trig), 32'd0);
        run(2, 0, 10000, -1, rise);
        chk("no auto no hold", 32'(rise), 32'hFFFF_FFFF);

        // Falling square wave 200/0, 8 clocks each level: trigger at index 24.
        @(negedge CLOCK_50);
        reset_n    = 1'b0;
        trig_slope = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        run(3, 0, 400, -1, rise);
        chk("fall hold index", 32'(rise), 32'd72);
        rd(16, d); chk("fall rd16", 32'(d), 32'd0);
        rd(15, d); chk("fall rd15", 32'(d), 32'd200);
        rd(0, d);  chk("fall rd0", 32'(d), 32'd0);
        rd(63, d); chk("fall rd63", 32'(d), 32'd200);

        // Rearm on the trigger strobe (index 100) discards it; next trigger is at 356.
        @(negedge CLOCK_50);
        reset_n    = 1'b0;
        trig_slope = 1'b1;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        run(0, 0, 160, 100, rise);
        chk("rearm on trigger no hold", 32'(rise), 32'hFFFF_FFFF);
        @(negedge CLOCK_50);
        run(0, 161, 360, -1, rise);
        chk("retrigger still in post", 32'(rise), 32'hFFFF_FFFF);

        // Reset mid-POST: outputs clear immediately and the frame never completes.
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        chk("post reset rd_data", 32'(disp.rd_data), 32'd0);
        chk("post reset frame_valid", 32'(disp.frame_valid), 32'd0);
        chk("post reset auto_trig", 32'(disp.auto_trig), 32'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        run(0, 0, 120, -1, rise);
        chk("post reset frame dropped", 32'(rise), 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
